// File: rtl/keypad_matrix_emulator.sv
// Keypad-side model of a 4x4 matrix keypad. It answers the scanner's one-hot column drive with
// the row of one requested key, including contact bounce on press and on release.
module keypad_matrix_emulator #(
    parameter int unsigned BOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES   = 20,
    parameter int unsigned GAP_CYCLES    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    input  logic [4:0] key_code,
    input  logic       press_req,
    output logic [3:0] fila,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        StIdle,
        StBounceIn,
        StHold,
        StBounceOut,
        StGap
    } state_e;

    localparam logic [15:0] BounceLast = 16'(BOUNCE_CYCLES - 1);
    localparam logic [15:0] HoldLast   = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GapLast    = 16'(GAP_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  code_q, code_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        key_active;
    logic [3:0]  key_col;
    logic [3:0]  key_row;

    // Sequencer: the phase counter restarts on every state entry.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 16'd1;
        code_d     = code_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        key_active = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (press_req) begin
                    if (key_code[4]) begin
                        error_d = 1'b1;
                    end else begin
                        code_d  = key_code[3:0];
                        state_d = StBounceIn;
                    end
                end
            end
            StBounceIn: begin
                key_active = ~cnt_q[0];
                if (cnt_q == BounceLast) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end
            end
            StHold: begin
                key_active = 1'b1;
                if (cnt_q == HoldLast) begin
                    state_d = StBounceOut;
                    cnt_d   = '0;
                end
            end
            StBounceOut: begin
                key_active = cnt_q[0];
                if (cnt_q == BounceLast) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            code_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Physical key placement: columns 1..4, rows 1..4.
    always_comb begin
        key_col = 4'b0000;
        key_row = 4'b0000;
        unique case (code_q)
            4'h1: begin key_col = 4'b0001; key_row = 4'b0001; end
            4'h4: begin key_col = 4'b0001; key_row = 4'b0010; end
            4'h7: begin key_col = 4'b0001; key_row = 4'b0100; end
            4'hF: begin key_col = 4'b0001; key_row = 4'b1000; end
            4'h2: begin key_col = 4'b0010; key_row = 4'b0001; end
            4'h5: begin key_col = 4'b0010; key_row = 4'b0010; end
            4'h8: begin key_col = 4'b0010; key_row = 4'b0100; end
            4'h0: begin key_col = 4'b0010; key_row = 4'b1000; end
            4'h3: begin key_col = 4'b0100; key_row = 4'b0001; end
            4'h6: begin key_col = 4'b0100; key_row = 4'b0010; end
            4'h9: begin key_col = 4'b0100; key_row = 4'b0100; end
            4'hE: begin key_col = 4'b0100; key_row = 4'b1000; end
            4'hA: begin key_col = 4'b1000; key_row = 4'b0001; end
            4'hB: begin key_col = 4'b1000; key_row = 4'b0010; end
            4'hC: begin key_col = 4'b1000; key_row = 4'b0100; end
            4'hD: begin key_col = 4'b1000; key_row = 4'b1000; end
            default: begin key_col = 4'b0000; key_row = 4'b0000; end
        endcase
    end

    // Combinational so the scanner sees the row in the same cycle it drives the column.
    assign fila  = (key_active && (col == key_col)) ? key_row : 4'b0000;
    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed self-checking bench for keypad_matrix_emulator: default instance plus one with
// BOUNCE_CYCLES = 3 for the bounce-pattern scenario.
module tb_keypad_matrix_emulator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col = 4'b0000;
    logic [4:0] key_code = 5'd0;
    logic       press_req = 1'b0;
    logic [3:0] fila;
    logic       busy, done, error;

    logic [3:0] col3 = 4'b0000;
    logic [4:0] key_code3 = 5'd0;
    logic       press_req3 = 1'b0;
    logic [3:0] fila3;
    logic       busy3, done3, error3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    keypad_matrix_emulator dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .key_code  (key_code),
        .press_req (press_req),
        .fila      (fila),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    keypad_matrix_emulator #(
        .BOUNCE_CYCLES (3),
        .HOLD_CYCLES   (20),
        .GAP_CYCLES    (8)
    ) dut3 (
        .clk       (clk),
        .rst       (rst),
        .col       (col3),
        .key_code  (key_code3),
        .press_req (press_req3),
        .fila      (fila3),
        .busy      (busy3),
        .done      (done3),
        .error     (error3)
    );

    // Expected key contact for offset i from the first BOUNCE_IN cycle.
    function automatic logic exp_active(input int i, input int b, input int h);
        if (i < b) return (i % 2) == 0;
        if (i < b + h) return 1'b1;
        if (i < 2 * b + h) return ((i - b - h) % 2) == 1;
        return 1'b0;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns at the start of the first BOUNCE_IN cycle.
    task automatic request(input logic [4:0] code);
        key_code  = code;
        press_req = 1'b1;
        next_cycle();
        press_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] cols [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b1111};
        rst = 1'b1;
        next_cycle();
        next_cycle();
        foreach (cols[k]) begin
            col = cols[k];
            @(negedge clk);
            checks++;
            if (fila !== 4'b0000) begin
                failures++;
                $display("FAIL reset_fila col=%b got=%b exp=0000", col, fila);
            end
        end
        checks++;
        if ({busy, done, error, busy3, done3, error3} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000", {busy, done, error, busy3, done3, error3});
        end
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_key5();
        int hold_hits = 0;
        logic [3:0] exp;
        request(5'd5);
        for (int i = 0; i < 36; i++) begin
            col = 4'(1 << (i % 4));
            @(negedge clk);
            exp = (col == 4'b0010 && exp_active(i, 4, 20)) ? 4'b0010 : 4'b0000;
            checks++;
            if (fila !== exp || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL key5_cycle i=%0d col=%b got fila=%b busy=%b done=%b exp fila=%b busy=1 done=0",
                         i, col, fila, busy, done, exp);
            end
            if (i >= 4 && i < 24 && fila == 4'b0010) hold_hits++;
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL key5_done got busy=%b done=%b exp busy=0 done=1", busy, done);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL key5_done_pulse got done=%b exp=0", done);
        end
        checks++;
        if (hold_hits != 5) begin
            failures++;
            $display("FAIL key5_hold_hits got=%0d exp=5", hold_hits);
        end
        next_cycle();
    endtask

    task automatic test_key_e_bounce();
        logic [3:0] exp;
        col3       = 4'b0100;
        key_code3  = 5'hE;
        press_req3 = 1'b1;
        next_cycle();
        press_req3 = 1'b0;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            exp = exp_active(i, 3, 20) ? 4'b1000 : 4'b0000;
            checks++;
            if (fila3 !== exp || busy3 !== 1'b1) begin
                failures++;
                $display("FAIL keyE_phase i=%0d got fila=%b busy=%b exp fila=%b busy=1",
                         i, fila3, busy3, exp);
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (busy3 !== 1'b0 || done3 !== 1'b1) begin
            failures++;
            $display("FAIL keyE_done got busy=%b done=%b exp busy=0 done=1", busy3, done3);
        end
        next_cycle();
    endtask

    task automatic test_invalid_code();
        col       = 4'b0010;
        key_code  = 5'd17;
        press_req = 1'b1;
        @(negedge clk);
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL invalid_early got error=%b exp=0", error);
        end
        next_cycle();
        press_req = 1'b0;
        @(negedge clk);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || fila !== 4'b0000) begin
            failures++;
            $display("FAIL invalid_error got error=%b busy=%b fila=%b exp error=1 busy=0 fila=0000",
                     error, busy, fila);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (error !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL invalid_pulse got error=%b busy=%b exp error=0 busy=0", error, busy);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp;
        col = 4'b0001;
        request(5'd1);
        for (int i = 0; i < 36; i++) begin
            key_code  = (i == 10) ? 5'd9 : 5'd1;
            press_req = (i == 10);
            @(negedge clk);
            exp = exp_active(i, 4, 20) ? 4'b0001 : 4'b0000;
            checks++;
            if (fila !== exp || busy !== 1'b1 || error !== 1'b0) begin
                failures++;
                $display("FAIL busy_req i=%0d got fila=%b busy=%b error=%b exp fila=%b busy=1 error=0",
                         i, fila, busy, error, exp);
            end
            next_cycle();
        end
        key_code  = 5'd9;
        press_req = 1'b1;
        col       = 4'b0100;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done got done=%b busy=%b exp done=1 busy=0", done, busy);
        end
        next_cycle();
        press_req = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || fila !== 4'b0100 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_start got busy=%b fila=%b done=%b exp busy=1 fila=0100 done=0",
                     busy, fila, done);
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fila !== 4'b0000) begin
            failures++;
            $display("FAIL b2b_cleanup got busy=%b fila=%b exp busy=0 fila=0000", busy, fila);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_hold();
        col = 4'b0010;
        request(5'd0);
        for (int i = 0; i < 10; i++) next_cycle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (fila !== 4'b1000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_hold_before got fila=%b busy=%b exp fila=1000 busy=1", fila, busy);
        end
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (fila !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL rst_hold_after i=%0d got fila=%b busy=%b done=%b exp 0000/0/0",
                         i, fila, busy, done);
            end
            next_cycle();
        end
        request(5'd0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || fila !== 4'b1000) begin
            failures++;
            $display("FAIL rst_hold_restart got busy=%b fila=%b exp busy=1 fila=1000", busy, fila);
        end
        for (int i = 0; i < 36; i++) next_cycle();
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL rst_hold_done got done=%b exp=1", done);
        end
        next_cycle();
    endtask

    task automatic test_bad_col();
        logic [3:0] cols [5] = '{4'b0011, 4'b0000, 4'b0100, 4'b1100, 4'b0100};
        logic [3:0] exps [5] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
        col = 4'b0000;
        request(5'd3);
        for (int i = 0; i < 5; i++) next_cycle();
        foreach (cols[k]) begin
            col = cols[k];
            @(negedge clk);
            checks++;
            if (fila !== exps[k]) begin
                failures++;
                $display("FAIL bad_col col=%b got=%b exp=%b", col, fila, exps[k]);
            end
            next_cycle();
        end
        for (int i = 10; i < 36; i++) next_cycle();
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bad_col_done got done=%b busy=%b exp done=1 busy=0", done, busy);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_key5();
        test_key_e_bounce();
        test_invalid_code();
        test_back_to_back();
        test_reset_mid_hold();
        test_bad_col();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
